// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with registered read port, out-of-range detection
// and a clear engine that sweeps every word to INIT_VAL after reset or on clr.
module ram_sp_clr #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 6,
    parameter int                DEPTH    = 64,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ip,
    input  logic [ADDR_W-1:0] add,
    input  logic              wr,
    input  logic              rd,
    input  logic              clr,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              busy,
    output logic              err
);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    // DEPTH may equal 2**ADDR_W, so the range check needs one extra bit
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] q_q;
    logic              q_valid_q;
    logic              busy_q;
    logic              err_q;

    logic              in_range;
    logic [DATA_W-1:0] rd_data;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_wa_d;
    logic [DATA_W-1:0] mem_wd_d;

    assign in_range = {1'b0, add} < DEPTH_W;
    assign rd_data  = wr ? ip : mem[add];

    // A clr during the sweep only restarts it, so that edge skips its write
    always_comb begin
        mem_we_d = 1'b0;
        mem_wa_d = cnt_q;
        mem_wd_d = INIT_VAL;
        if (rst_n) begin
            if (state_q == ST_CLEAR) begin
                mem_we_d = !clr;
            end else if (!clr && wr && in_range) begin
                mem_we_d = 1'b1;
                mem_wa_d = add;
                mem_wd_d = ip;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem[mem_wa_d] <= mem_wd_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            q_valid_q <= 1'b0;
            err_q     <= 1'b0;
            if (state_q == ST_CLEAR) begin
                if (clr) begin
                    cnt_q <= '0;
                end else begin
                    err_q <= wr | rd;
                    if (cnt_q == LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
            end else if (clr) begin
                state_q <= ST_CLEAR;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
            end else begin
                err_q <= (wr | rd) & !in_range;
                if (rd) begin
                    q_valid_q <= 1'b1;
                    q_q       <= in_range ? rd_data : '0;
                end
            end
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench for ram_sp_clr: a 64-word and a 40-word instance share one stimulus
// stream and are checked every cycle against an abstract model plus literals.
module tb_ram_sp_clr;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ip    = '0;
    logic [5:0] add   = '0;
    logic       wr    = 1'b0;
    logic       rd    = 1'b1;
    logic       clr   = 1'b0;

    logic [7:0] q_a, q_b;
    logic       qv_a, qv_b, busy_a, busy_b, err_a, err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_sp_clr #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .INIT_VAL(8'hA5)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .ip(ip), .add(add), .wr(wr), .rd(rd), .clr(clr),
        .q(q_a), .q_valid(qv_a), .busy(busy_a), .err(err_a)
    );

    ram_sp_clr #(.DATA_W(8), .ADDR_W(6), .DEPTH(40), .INIT_VAL(8'hA5)) u_dut40 (
        .clk(clk), .rst_n(rst_n), .ip(ip), .add(add), .wr(wr), .rd(rd), .clr(clr),
        .q(q_b), .q_valid(qv_b), .busy(busy_b), .err(err_b)
    );

    // Model: a sweep is just "edges remaining"; when it ends every word is INIT
    logic [7:0] mmem [2][64];
    int         rem  [2] = '{64, 40};
    logic [7:0] mq   [2] = '{8'h00, 8'h00};
    logic       mqv  [2] = '{1'b0, 1'b0};
    logic       merr [2] = '{1'b0, 1'b0};

    function automatic int dep(input int k);
        return (k == 0) ? 64 : 40;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                rem[k]  = dep(k);
                mq[k]   = 8'h00;
                mqv[k]  = 1'b0;
                merr[k] = 1'b0;
            end else if (rem[k] > 0) begin
                mqv[k]  = 1'b0;
                merr[k] = (wr || rd) && !clr;
                if (clr) begin
                    rem[k] = dep(k);
                end else begin
                    rem[k] = rem[k] - 1;
                    if (rem[k] == 0)
                        for (int j = 0; j < 64; j++) mmem[k][j] = 8'hA5;
                end
            end else if (clr) begin
                rem[k]  = dep(k);
                mqv[k]  = 1'b0;
                merr[k] = 1'b0;
            end else begin
                logic inr;
                inr     = int'(add) < dep(k);
                merr[k] = (wr || rd) && !inr;
                mqv[k]  = rd;
                if (rd) mq[k] = !inr ? 8'h00 : (wr ? ip : mmem[k][add]);
                if (wr && inr) mmem[k][add] = ip;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("q64",     q_a,    mq[0]);
        chk("qv64",    qv_a,   mqv[0]);
        chk("busy64",  busy_a, rem[0] > 0);
        chk("err64",   err_a,  merr[0]);
        chk("q40",     q_b,    mq[1]);
        chk("qv40",    qv_b,   mqv[1]);
        chk("busy40",  busy_b, rem[1] > 0);
        chk("err40",   err_b,  merr[1]);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_q", q_a, 8'h00);
        chk("rst_busy", busy_a, 1'b1);
        rst_n = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            cyc();
            if (i == 10) chk("err_while_busy", err_a, 1'b1);
            if (i == 63) chk("busy_63", busy_a, 1'b1);
            if (i == 64) chk("busy_64", busy_a, 1'b0);
        end
        cyc();
        chk("first_read_q", q_a, 8'hA5);
        chk("first_read_qv", qv_a, 1'b1);

        rd = 1'b0;
        wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            add = 6'(i);
            ip  = 8'(i + 1);
            cyc();
        end
        wr = 1'b0;
        rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            add = 6'(i);
            cyc();
            chk("rd_back_q", q_a, 32'(i + 1));
            chk("rd_back_qv", qv_a, 1'b1);
        end

        wr  = 1'b1;
        add = 6'd5;
        ip  = 8'h11;
        cyc();
        chk("wf_q", q_a, 8'h11);
        chk("wf_qv", qv_a, 1'b1);
        wr = 1'b0;
        cyc();
        chk("wf_reread", q_a, 8'h11);

        rd  = 1'b0;
        clr = 1'b1;
        wr  = 1'b1;
        add = 6'd6;
        ip  = 8'h22;
        cyc();
        chk("clr_busy", busy_a, 1'b1);
        chk("clr_no_err", err_a, 1'b0);
        clr = 1'b0;
        wr  = 1'b0;
        for (int i = 2; i <= 65; i++) begin
            cyc();
            if (i == 64) chk("clr_busy_64", busy_a, 1'b1);
            if (i == 65) chk("clr_busy_65", busy_a, 1'b0);
        end
        rd = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            add = 6'(i);
            cyc();
            chk("post_clr_q", q_a, 8'hA5);
        end

        rd  = 1'b0;
        wr  = 1'b1;
        add = 6'd45;
        ip  = 8'h33;
        cyc();
        chk("oor_wr_err40", err_b, 1'b1);
        chk("inr_wr_err64", err_a, 1'b0);
        wr = 1'b0;
        rd = 1'b1;
        cyc();
        chk("oor_rd_q40", q_b, 8'h00);
        chk("oor_rd_qv40", qv_b, 1'b1);
        chk("oor_rd_err40", err_b, 1'b1);
        chk("inr_rd_q64", q_a, 8'h33);

        rd  = 1'b0;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (30) cyc();
        rst_n = 1'b0;
        #1;
        chk("midrst_q", q_a, 8'h00);
        chk("midrst_busy", busy_a, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            cyc();
            if (i == 63) chk("rst_sweep_63", busy_a, 1'b1);
            if (i == 64) chk("rst_sweep_64", busy_a, 1'b0);
        end
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_sp_clr.md
Name: ram_sp_clr

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed 8x64 RAM.
- Adds generic width and depth, an explicit read strobe with a registered read-valid, and out-of-range detection.
- Adds a hardware clear engine that sweeps every location to INIT_VAL after reset or on request.
- Used as generic scratch/buffer storage; the controlling logic must honour busy.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 6, address width in bits
DEPTH, 64, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
INIT_VAL, 0, value written to every word by the clear sweep (DATA_W bits)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
ip  input  DATA_W  write data
add  input  ADDR_W  word address for read/write
wr  input  1  write strobe, sampled at rising edge
rd  input  1  read strobe, sampled at rising edge
clr  input  1  clear request; starts a full sweep
q  output  DATA_W  registered read data
q_valid  output  1  one-cycle pulse, q updated by a read this cycle
busy  output  1  high while the clear sweep runs; user requests are ignored
err  output  1  one-cycle pulse: rejected or out-of-range access

Behaviour:
- Reset (rst_n=0, asynchronous): state=CLEAR, sweep counter=0, q=0, q_valid=0, busy=1, err=0. Array contents are not reset directly.
- FSM states:
  - CLEAR: each edge writes INIT_VAL to mem[cnt] and increments cnt. On the edge that writes DEPTH-1, go to IDLE and clear cnt.
  - After rst_n rises, busy falls after exactly DEPTH rising edges.
  - IDLE: serves user requests.
- busy = (state==CLEAR), registered.
- clr in IDLE:
  - Next edge enters CLEAR with cnt=0.
  - wr/rd in the same cycle are ignored; err is not raised.
  - Sweep writes occur on the following DEPTH edges.
- clr during CLEAR: restart the sweep at cnt=0.
- wr or rd while busy=1 (and clr=0): request is dropped and err pulses the next cycle. Memory and q are unchanged.
- Write (IDLE, wr=1, add<DEPTH): mem[add]<=ip at the edge.
- Read (IDLE, rd=1, add<DEPTH):
  - q<=mem[add] at the edge; q_valid=1 for the following cycle. Read latency is 1 clock.
- wr=1 and rd=1, same cycle: write-first. The memory is written and q<=ip, with q_valid pulsing.
- q holds its last value when no read occurs; q_valid=0 in those cycles.
- add>=DEPTH (only possible when DEPTH<2**ADDR_W):
  - A write is discarded.
  - A read returns q=0 with q_valid=1.
  - err pulses in both cases.
- err and q_valid are single-cycle, registered, and never sticky.
- Reset asserted mid-sweep or mid-access: the asynchronous reset wins; the sweep restarts from 0 after release.

Test Plan:
- Defaults, INIT_VAL=8'hA5. Release rst_n, hold rd=1 add=0 throughout:
  - busy=1 for 64 edges, err pulses while busy.
  - Then busy=0, q=8'hA5 with q_valid=1 one cycle later.
- Write 8'h01..8'h05 to add 0..4 (wr=1), then rd add 0..4 with wr=0:
  - q=8'h01..8'h05, each one cycle after its address, with q_valid=1 each cycle.
- wr=1, rd=1, add=5, ip=8'h11 in the same cycle:
  - Next cycle q=8'h11, q_valid=1.
  - A later read of add 5 also returns 8'h11.
- After the writes above, pulse clr with wr=1 add=6 ip=8'h22:
  - busy=1 for 64 cycles, no err.
  - Afterwards reads of add 0..6 all return 8'hA5.
- DEPTH=40: wr add=45 ip=8'h33 -> err pulse, no write. Then rd add=45 -> q=0, q_valid=1, err pulse.
- Assert rst_n=0 for 1 cycle at sweep cnt=30: q=0, busy stays 1, and the sweep takes the full 64 cycles after release.
